// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART receiver and transmitter
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int CPB_MIN   = 2;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous input, resets to 1 (line idle)
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;
    always_ff @(posedge clk or posedge rst)
        if (rst) ff <= '1;
        else ff <= {ff[SYNC_STAGES-2:0], d};
    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CPB_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             rx_enable,
    input  logic [CPB_W-1:0] cpb,
    output logic [7:0]       data_rx,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);
    localparam logic [CPB_W-1:0] ONE = CPB_W'(1);
    localparam logic [CPB_W-1:0] MIN = CPB_W'(CPB_MIN);
    uart_state_t state, state_n;
    logic rx_s, rx_d, tick, valid_n, ferr_n;
    logic [CPB_W-1:0] cnt, cnt_n, cpb_q, cpb_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift, shift_n, data_n;
`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n, perr_n;
`endif

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

    assign tick = cnt == cpb_q - ONE;
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + ONE;
        cpb_n   = cpb_q;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = data_rx;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        if (state != IDLE && !rx_enable) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (rx_enable && rx_d && !rx_s) begin
                        state_n = START;
                        cpb_n   = cpb < MIN ? MIN : cpb;
                    end
                end
                START: if (cnt == cpb_q >> 1) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    bit_n   = bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_n = PARITY;
`else
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_n = STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    cnt_n     = '0;
                    par_bad_n = rx_s != ^shift;
                    state_n   = STOP;
                end
`endif
                STOP: if (tick) begin
                    cnt_n   = '0;
                    data_n  = shift;
                    ferr_n  = !rx_s;
                    state_n = rx_s ? IDLE : WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    valid_n = rx_s && !par_bad;
                    perr_n  = rx_s && par_bad;
`else
                    valid_n = rx_s;
`endif
                end
                WAIT_HIGH: begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : WAIT_HIGH;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rx_d      <= 1'b1;
            cnt       <= '0;
            cpb_q     <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_rx   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            rx_d      <= rx_s;
            cnt       <= cnt_n;
            cpb_q     <= cpb_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            data_rx   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= perr_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a frame-level scoreboard predicting each pulse, its byte and its cycle
module tb_uart_receiver;
    localparam int CPB_W = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam logic [2:0] K_VALID = 3'b100, K_FERR = 3'b010, K_PERR = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         due;
    } ev_t;

    logic clk = 1'b0, rst = 1'b0, rx = 1'b1, rx_enable = 1'b1;
    logic [CPB_W-1:0] cpb = 16;
    logic [7:0] data_rx, last_data = 8'h00;
    logic rx_valid, frame_err, parity_err, busy;
    int errors = 0, checks = 0, cyc = 0, nvalid = 0, npulse;
    ev_t exp_q[$];
    ev_t ev;

    uart_receiver #(.CPB_W(CPB_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_enable(rx_enable), .cpb(cpb),
        .data_rx(data_rx), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one frame from a negedge; the pulse is due 2 sync + 1 edge-detect cycles,
    // half a bit, then 9 (10 with parity) full bits after the first edge seeing the start bit.
    task automatic send(input logic [7:0] d, input logic stop, input logic flip,
                        input int cpb_v, input int nbits, input logic track);
        logic bits [11];
        int nb = 10 + PAR;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
        bits[9]  = (PAR == 1) ? (^d ^ flip) : stop;
        bits[10] = stop;
        cpb = CPB_W'(cpb_v);
        if (track)
            exp_q.push_back('{!stop ? K_FERR : (PAR == 1 && flip) ? K_PERR : K_VALID, d,
                              cyc + 4 + cpb_v / 2 + (9 + PAR) * cpb_v});
        for (int i = 0; i < nbits && i < nb; i++) begin
            rx = bits[i];
            repeat (cpb_v) @(negedge clk);
        end
        rx = (nbits >= nb) ? stop : 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {data_rx, rx_valid, frame_err, parity_err, busy}, 0);
            last_data = 8'h00;
        end else begin
            npulse = int'(rx_valid) + int'(frame_err) + int'(parity_err);
            if (npulse != 0) begin
                check("one_pulse_at_a_time", npulse, 1);
                if (rx_valid) nvalid++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {rx_valid, frame_err, parity_err}, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", {rx_valid, frame_err, parity_err}, ev.kind);
                    check("pulse_data", data_rx, ev.data);
                    check("pulse_cycle", cyc, ev.due);
                end
                last_data = data_rx;
            end else begin
                check("data_hold", data_rx, last_data);
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data_rx, 8'h00);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        fork
            send(8'hA5, 1'b1, 1'b0, 16, 11, 1'b1);
            begin
                repeat (40) @(negedge clk);
                check("busy_mid_frame", busy, 1);
            end
        join
        repeat (20) @(negedge clk);
        check("a5_data", data_rx, 8'hA5);
        check("a5_valid_count", nvalid, 1);
        check("a5_busy_after", busy, 0);
        check("a5_pending", exp_q.size(), 0);

        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_in_start", busy, 1);
        repeat (20) @(negedge clk);
        check("glitch_idle", busy, 0);
        check("glitch_data", data_rx, 8'hA5);

        send(8'h3C, 1'b0, 1'b0, 16, 11, 1'b1);
        repeat (100) @(negedge clk);
        check("break_busy", busy, 1);
        check("break_data", data_rx, 8'h3C);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_released", busy, 0);
        repeat (40) @(negedge clk);
        check("break_pending", exp_q.size(), 0);

        send(8'h00, 1'b1, 1'b0, 8, 11, 1'b1);
        send(8'hFF, 1'b1, 1'b0, 8, 11, 1'b1);
        repeat (20) @(negedge clk);
        check("b2b_data", data_rx, 8'hFF);
        check("b2b_valid_count", nvalid, 3);
        check("b2b_pending", exp_q.size(), 0);

        fork
            send(8'h96, 1'b1, 1'b0, 16, 11, 1'b0);
            begin
                repeat (60) @(negedge clk);
                rx_enable = 1'b0;
                repeat (2) @(negedge clk);
                check("abort_idle", busy, 0);
            end
        join
        repeat (10) @(negedge clk);
        rx_enable = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_data", data_rx, 8'hFF);

        send(8'h55, 1'b1, 1'b0, 16, 4, 1'b0);
        check("rst_mid_data_busy", busy, 1);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_data_cleared", data_rx, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send(8'h81, 1'b1, 1'b0, 16, 11, 1'b1);
        repeat (20) @(negedge clk);
        check("after_rst_data", data_rx, 8'h81);
        check("after_rst_valid_count", nvalid, 4);
        check("after_rst_pending", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 16, 11, 1'b1);
        repeat (20) @(negedge clk);
        check("par_bad_no_valid", nvalid, 4);
        send(8'h07, 1'b1, 1'b0, 16, 11, 1'b1);
        repeat (20) @(negedge clk);
        check("par_good_valid", nvalid, 5);
        check("par_pending", exp_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL provide parameter CPB_W, default 16, width of the clock-per-bit input and internal bit counter.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, number of flops in the rx input synchronizer (min 2).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rx_enable  input  1  receiver enable; 0 holds block in IDLE.
REQ-007 cpb  input  CPB_W  clocks per bit, sampled at start-bit detection.
REQ-008 data_rx  output  8  last received byte, LSB first on line.
REQ-009 rx_valid  output  1  one-cycle pulse: data_rx updated with a good frame.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without macro).
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 rx SHALL pass through SYNC_STAGES flops; all decisions use synchronized value rx_s and its one-cycle-delayed copy.
REQ-014 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-015 IDLE -> START when rx_enable=1 and rx_s falling edge (prev 1, now 0); cpb latched into cpb_q, counter cleared.
REQ-016 cpb_q SHALL be clamped to minimum 2; cpb changes mid-frame have no effect.
REQ-017 START: at counter = cpb_q>>1 sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch reject, no outputs).
REQ-018 DATA: sample every cpb_q clocks, shift into bit 7 of shift register (LSB first); after 8th sample -> PARITY or STOP.
REQ-019 PARITY: sample after cpb_q clocks; compare with even parity of the 8 data bits.
REQ-020 STOP: sample after cpb_q clocks; 1 -> data_rx loaded, rx_valid (or parity_err instead if mismatch) pulsed next cycle, -> IDLE.
REQ-021 STOP sampled 0 -> data_rx loaded, frame_err pulsed, rx_valid not pulsed, -> WAIT_HIGH.
REQ-022 WAIT_HIGH -> IDLE only once rx_s = 1 (break condition never re-triggers a frame).
REQ-023 rx_enable falling mid-frame SHALL abort to IDLE next cycle with no pulses and data_rx unchanged.
REQ-024 data_rx SHALL hold its value between frames; rx_valid, frame_err, parity_err never assert together.
REQ-025 Back-to-back frames: falling edge detected in first IDLE cycle after STOP SHALL start the next frame.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, synchronizer flops to 1, counter 0, cpb_q 0, data_rx 8'h00, rx_valid/frame_err/parity_err/busy 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; no pulse after release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state present, even parity checked, parity_err driven per REQ-020.
REQ-029 Macro undefined: no PARITY state, frame is 8N1, parity_err tied 0.

Structure
REQ-030 Package uart_pkg SHALL hold state enum, DATA_BITS=8, CPB minimum constant, shared with the transmitter.
REQ-031 Synchronizer SHALL be sub-module uart_sync (parameter SYNC_STAGES, reset value 1).

Verification
REQ-032 cpb=16, frame 0xA5 8N1 -> data_rx=8'hA5, single rx_valid pulse, no errors, busy falls after stop.
REQ-033 cpb=16, rx low 5 cycles then high -> returns IDLE, no pulses, data_rx unchanged.
REQ-034 cpb=16, 0x3C with stop bit 0, line held low 100 cycles -> frame_err one pulse, stays WAIT_HIGH until rx=1, no spurious frame.
REQ-035 cpb=8, 0x00 then 0xFF back-to-back -> two rx_valid pulses, data_rx 8'h00 then 8'hFF.
REQ-036 rst asserted mid-DATA of 0x55, then clean 0x81 -> only 0x81 reported, outputs 0 during reset.
REQ-037 With UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_valid.
